// File: rtl/led_fader.sv
// led_fader: per-channel brightness ramp engine feeding a 3-channel LED PWM block.
//
// The CPU programs target brightness and a ramp step through a byte register bank.
// On every prescaler tick, with enable set, each channel's current brightness moves
// toward its target. Every changed channel is pushed to the PWM write port, one
// channel per write, with one idle cycle between writes.
//
// Register map (addr):
//   0..2  target[ch]   rw
//   3     step         rw
//   4..6  current[ch]  ro (writes ignored)
//   7     status       bit7 enable (rw), bits2..0 ramping[ch] (ro), others read 0
//
// Parameters:
//   PRESCALE     clocks per ramp tick, 8..2^24
//
// Ports:
//   clk          system clock
//   rst_n        synchronous reset, active low
//   rd_en        CPU read strobe; rd_data/rd_valid appear on the next cycle
//   addr         CPU register address
//   rd_data      CPU read data
//   rd_valid     one-cycle read-valid pulse
//   wr_en        CPU write strobe
//   wr_data      CPU write data
//   led_wr_en    PWM write strobe
//   led_addr     PWM channel index 0..2
//   led_wr_data  PWM compare value, f(current)
//
// Build option:
//   LED_FADER_GAMMA_EN  when defined, f(c) = (c*c + 255) >> 8; otherwise f(c) = c.
//   Register readback always returns the linear current value.

module led_fader #(
  parameter int unsigned PRESCALE = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rd_en,
  input  logic [2:0] addr,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       led_wr_en,
  output logic [1:0] led_addr,
  output logic [7:0] led_wr_data
);

  localparam int unsigned CntW = 24;
  localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } state_e;

  // Move cur toward tgt by stp without passing tgt. 9-bit arithmetic keeps the
  // carry/borrow so there is no wrap-around past 255 or 0. stp == 0 snaps.
  function automatic logic [7:0] ramp_next(input logic [7:0] cur, input logic [7:0] tgt,
                                           input logic [7:0] stp);
    logic [8:0] up;
    logic [8:0] dn;
    logic [7:0] res;
    up = {1'b0, cur} + {1'b0, stp};
    dn = {1'b0, cur} - {1'b0, stp};
    res = cur;
    if (stp == 8'd0) begin
      res = tgt;
    end else if (cur < tgt) begin
      res = (up > {1'b0, tgt}) ? tgt : up[7:0];
    end else if (cur > tgt) begin
      // dn[8] is the borrow: step larger than current.
      res = (dn[8] || (dn[7:0] < tgt)) ? tgt : dn[7:0];
    end
    return res;
  endfunction

  // Brightness shaping applied on the way to the PWM block only.
  function automatic logic [7:0] shape(input logic [7:0] c);
`ifdef LED_FADER_GAMMA_EN
    logic [16:0] sq;
    sq = ({9'd0, c} * {9'd0, c}) + 17'd255;
    return sq[15:8];
`else
    return c;
`endif
  endfunction

  // State
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0][7:0] target_q, target_d;
  logic [2:0][7:0] current_q, current_d;
  logic [7:0]      step_q, step_d;
  logic            enable_q, enable_d;
  logic [2:0]      dirty_q, dirty_d;
  logic [7:0]      rd_data_q;
  logic            rd_valid_q;
  state_e          state_q;
  logic            led_wr_en_q;
  logic [1:0]      led_addr_q;
  logic [7:0]      led_wr_data_q;

  // Combinational helpers
  logic       tick;
  logic [2:0] changed;
  logic [2:0] ramping;
  logic       push_go;
  logic [1:0] push_ch;
  logic [7:0] rd_mux;

  assign tick = (cnt_q == CntMax);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      ramping[i] = (current_q[i] != target_q[i]);
    end
  end

  // Lowest-index dirty channel wins.
  always_comb begin
    push_ch = 2'd0;
    if (dirty_q[0]) begin
      push_ch = 2'd0;
    end else if (dirty_q[1]) begin
      push_ch = 2'd1;
    end else if (dirty_q[2]) begin
      push_ch = 2'd2;
    end
  end

  assign push_go = (state_q == StIdle) && (dirty_q != 3'b000);

  // Next-state for prescaler, register bank, ramp and dirty flags.
  always_comb begin
    cnt_d     = tick ? '0 : cnt_q + CntW'(1);
    target_d  = target_q;
    current_d = current_q;
    step_d    = step_q;
    enable_d  = enable_q;
    changed   = 3'b000;

    // Ramp sees the pre-write target/step, so a coincident CPU write lands after it.
    if (tick && enable_q) begin
      for (int i = 0; i < 3; i++) begin
        current_d[i] = ramp_next(current_q[i], target_q[i], step_q);
        changed[i]   = (current_d[i] != current_q[i]);
      end
    end

    if (wr_en) begin
      case (addr)
        3'd0:    target_d[0] = wr_data;
        3'd1:    target_d[1] = wr_data;
        3'd2:    target_d[2] = wr_data;
        3'd3:    step_d      = wr_data;
        3'd7:    enable_d    = wr_data[7];
        default: ;
      endcase
    end

    // A change on the same edge as a push clear must re-arm the channel.
    dirty_d = dirty_q;
    if (push_go) begin
      dirty_d[push_ch] = 1'b0;
    end
    dirty_d = dirty_d | changed;
  end

  // CPU read mux, sampled from pre-edge register state.
  always_comb begin
    rd_mux = 8'd0;
    case (addr)
      3'd0:    rd_mux = target_q[0];
      3'd1:    rd_mux = target_q[1];
      3'd2:    rd_mux = target_q[2];
      3'd3:    rd_mux = step_q;
      3'd4:    rd_mux = current_q[0];
      3'd5:    rd_mux = current_q[1];
      3'd6:    rd_mux = current_q[2];
      3'd7:    rd_mux = {enable_q, 4'b0000, ramping};
      default: rd_mux = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      target_q   <= '0;
      current_q  <= '0;
      step_q     <= 8'd1;
      enable_q   <= 1'b0;
      dirty_q    <= 3'b111;
      rd_data_q  <= 8'd0;
      rd_valid_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      current_q  <= current_d;
      step_q     <= step_d;
      enable_q   <= enable_d;
      dirty_q    <= dirty_d;
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= rd_mux;
      end
    end
  end

  // Push FSM: one PWM write, then one idle cycle, so writes come every other cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      led_wr_en_q   <= 1'b0;
      led_addr_q    <= 2'd0;
      led_wr_data_q <= 8'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (push_go) begin
            led_wr_en_q   <= 1'b1;
            led_addr_q    <= push_ch;
            led_wr_data_q <= shape(current_q[push_ch]);
            state_q       <= StSend;
          end else begin
            led_wr_en_q <= 1'b0;
          end
        end
        StSend: begin
          led_wr_en_q <= 1'b0;
          state_q     <= StIdle;
        end
        default: begin
          led_wr_en_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign led_wr_en   = led_wr_en_q;
  assign led_addr    = led_addr_q;
  assign led_wr_data = led_wr_data_q;

endmodule
